// File: rtl/imm_pack_encoder_rv32i_pkg.sv
// Shared types and constants for the RV32I immediate packer.
package imm_pack_encoder_rv32i_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100
   } imm_type_e;

   // Highest immediate bit that must still match the sign bits above it.
   localparam int unsigned SGN_MSB_IS = 11;
   localparam int unsigned SGN_MSB_B  = 12;
   localparam int unsigned SGN_MSB_J  = 20;

   // Base opcodes, handy for benches and program loaders.
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   // True when v[31:msb] are all equal, i.e. v fits a (msb+1)-bit signed field.
   function automatic logic sign_ok(input logic [31:0] v, input int unsigned msb);
      logic [31:0] s;
      s = $unsigned($signed(v) >>> msb);
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/imm_pack_encoder_rv32i_if.sv
// Input and output valid/ready streams of the immediate packer.
interface imm_pack_encoder_rv32i_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_immtype;
   logic [31:0] in_imm;
   logic [31:0] in_base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;

   modport master (
      output in_valid, in_immtype, in_imm, in_base, out_ready,
      input  in_ready, out_valid, out_instr, out_addr
   );

   modport slave (
      input  in_valid, in_immtype, in_imm, in_base, out_ready,
      output in_ready, out_valid, out_instr, out_addr
   );
endinterface

// File: rtl/imm_pack_comb_rv32i.sv
// Combinational immediate packing and legality checks.
module imm_pack_comb_rv32i
   import imm_pack_encoder_rv32i_pkg::*;
(
   input  logic [2:0]  i_immtype,
   input  logic [31:0] i_imm,
   input  logic [31:0] i_base,
   output logic [31:0] o_instr,
   output logic        o_err_range,
   output logic        o_err_align,
   output logic        o_err_type
);

   // Overwrite the immediate fields of the base word and flag illegal immediates.
   always_comb begin
      o_instr     = i_base;
      o_err_range = 1'b0;
      o_err_align = 1'b0;
      o_err_type  = 1'b0;
      case (imm_type_e'(i_immtype))
         IMM_I: begin
            o_instr[31:20] = i_imm[11:0];
            o_err_range    = !sign_ok(i_imm, SGN_MSB_IS);
         end
         IMM_S: begin
            o_instr[31:25] = i_imm[11:5];
            o_instr[11:7]  = i_imm[4:0];
            o_err_range    = !sign_ok(i_imm, SGN_MSB_IS);
         end
         IMM_B: begin
            o_instr[31]    = i_imm[12];
            o_instr[30:25] = i_imm[10:5];
            o_instr[11:8]  = i_imm[4:1];
            o_instr[7]     = i_imm[11];
            o_err_range    = !sign_ok(i_imm, SGN_MSB_B);
            o_err_align    = i_imm[0];
         end
         IMM_U: begin
            o_instr[31:12] = i_imm[31:12];
            o_err_align    = (i_imm[11:0] != '0);
         end
         IMM_J: begin
            o_instr[31]    = i_imm[20];
            o_instr[30:21] = i_imm[10:1];
            o_instr[20]    = i_imm[11];
            o_instr[19:12] = i_imm[19:12];
            o_err_range    = !sign_ok(i_imm, SGN_MSB_J);
            o_err_align    = i_imm[0];
         end
         default: o_err_type = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_pack_encoder_rv32i.sv
// Stream wrapper: handshake, IMEM address generation, counters, sticky errors.
module imm_pack_encoder_rv32i
   import imm_pack_encoder_rv32i_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   imm_pack_encoder_rv32i_if.slave bus,
   input  logic                 addr_load,
   input  logic [31:0]          addr_value,
   output logic                 err_range,
   output logic                 err_align,
   output logic                 err_type,
   output logic [CNT_W-1:0]     word_count,
   output logic [CNT_W-1:0]     err_count
);

   logic             r_out_valid;
   logic [31:0]      r_out_instr;
   logic [31:0]      r_out_addr;
   logic [31:0]      r_next_addr;
   logic             r_err_range;
   logic             r_err_align;
   logic             r_err_type;
   logic [CNT_W-1:0] r_word_count;
   logic [CNT_W-1:0] r_err_count;

   logic [31:0]      w_instr;
   logic             w_err_range;
   logic             w_err_align;
   logic             w_err_type;
   logic             w_accept;
   logic             w_legal;
   logic             w_drain;
   logic [31:0]      w_addr_base;

   imm_pack_comb_rv32i u_pack (
      .i_immtype   (bus.in_immtype),
      .i_imm       (bus.in_imm),
      .i_base      (bus.in_base),
      .o_instr     (w_instr),
      .o_err_range (w_err_range),
      .o_err_align (w_err_align),
      .o_err_type  (w_err_type)
   );

   assign bus.in_ready = !r_out_valid || bus.out_ready;
   assign w_accept     = bus.in_valid && bus.in_ready;
   assign w_legal      = !(w_err_range || w_err_align || w_err_type);
   assign w_drain      = r_out_valid && bus.out_ready;
   // A same-cycle load takes priority over the running address.
   assign w_addr_base  = addr_load ? (addr_value & ~32'h3) : r_next_addr;

   // Output register stage and next-address counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_out_addr  <= BASE_ADDR;
         r_next_addr <= BASE_ADDR;
      end else begin
         if (w_accept && w_legal) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_instr;
            r_out_addr  <= w_addr_base;
            r_next_addr <= w_addr_base + 32'd4;
         end else begin
            if (w_drain) r_out_valid <= 1'b0;
            r_next_addr <= w_addr_base;
         end
      end
   end

   // Sticky error flags and saturating counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_range  <= 1'b0;
         r_err_align  <= 1'b0;
         r_err_type   <= 1'b0;
         r_word_count <= '0;
         r_err_count  <= '0;
      end else begin
         if (w_accept) begin
            if (w_err_range) r_err_range <= 1'b1;
            if (w_err_align) r_err_align <= 1'b1;
            if (w_err_type)  r_err_type  <= 1'b1;
            if (!w_legal && (r_err_count != '1)) r_err_count <= r_err_count + CNT_W'(1);
         end
         if (w_drain && (r_word_count != '1)) r_word_count <= r_word_count + CNT_W'(1);
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_instr = r_out_instr;
   assign bus.out_addr  = r_out_addr;
   assign err_range     = r_err_range;
   assign err_align     = r_err_align;
   assign err_type      = r_err_type;
   assign word_count    = r_word_count;
   assign err_count     = r_err_count;

endmodule

// File: tb/tb_imm_pack_encoder_rv32i.sv
// Self-checking bench: directed table, corner sequences and random stimulus
// against a cycle-level reference model built from the immediate rules.
module tb_imm_pack_encoder_rv32i;

   localparam logic [31:0] BASE = 32'h0000_2000;
   localparam int unsigned CW   = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          addr_load = 1'b0;
   logic [31:0]   addr_value = '0;
   logic          err_range, err_align, err_type;
   logic [CW-1:0] word_count, err_count;

   imm_pack_encoder_rv32i_if bus ();

   imm_pack_encoder_rv32i #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .addr_load  (addr_load),
      .addr_value (addr_value),
      .err_range  (err_range),
      .err_align  (err_align),
      .err_type   (err_type),
      .word_count (word_count),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic        m_ov;
   logic [31:0] m_instr, m_addr, m_next;
   logic        m_er, m_ea, m_et;
   int          m_wc, m_ec;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ov = 0; m_instr = '0; m_addr = BASE; m_next = BASE;
      m_er = 0; m_ea = 0; m_et = 0; m_wc = 0; m_ec = 0;
   endtask

   // Legality from signed value ranges.
   function automatic void ref_check(input logic [2:0] t, input logic [31:0] imm,
                                     output logic rg, output logic al, output logic ty);
      longint v;
      v = longint'($signed(imm));
      rg = 0; al = 0; ty = 0;
      case (t)
         3'd0, 3'd1: rg = (v < -2048) || (v > 2047);
         3'd2: begin rg = (v < -4096) || (v > 4095); al = (v % 2) != 0; end
         3'd3: al = (imm % 4096) != 0;
         3'd4: begin rg = (v < -(1 << 20)) || (v > (1 << 20) - 1); al = (v % 2) != 0; end
         default: ty = 1;
      endcase
   endfunction

   function automatic logic [31:0] ref_pack(input logic [2:0] t, input logic [31:0] imm,
                                            input logic [31:0] b);
      case (t)
         3'd0: return {imm[11:0], b[19:0]};
         3'd1: return {imm[11:5], b[24:12], imm[4:0], b[6:0]};
         3'd2: return {imm[12], imm[10:5], b[24:12], imm[4:1], imm[11], b[6:0]};
         3'd3: return {imm[31:12], b[11:0]};
         3'd4: return {imm[20], imm[10:1], imm[11], imm[19:12], b[11:0]};
         default: return b;
      endcase
   endfunction

   // One clock of stimulus; called #1 after a rising edge.
   task automatic cycle(input logic v, input logic [2:0] t, input logic [31:0] imm,
                        input logic [31:0] b, input logic rdy, input logic ld,
                        input logic [31:0] lv);
      logic exp_rdy, acc, rg, al, ty;
      logic [31:0] nb;
      bus.in_valid = v; bus.in_immtype = t; bus.in_imm = imm; bus.in_base = b;
      bus.out_ready = rdy; addr_load = ld; addr_value = lv;
      #1;
      exp_rdy = !m_ov || rdy;
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      acc = v && exp_rdy;
      nb  = ld ? {lv[31:2], 2'b00} : m_next;
      if (m_ov && rdy) begin
         if (m_wc < 65535) m_wc++;
         m_ov = 0;
      end
      m_next = nb;
      if (acc) begin
         ref_check(t, imm, rg, al, ty);
         if (rg || al || ty) begin
            m_er |= rg; m_ea |= al; m_et |= ty;
            if (m_ec < 65535) m_ec++;
         end else begin
            m_ov = 1; m_instr = ref_pack(t, imm, b); m_addr = nb; m_next = nb + 32'd4;
         end
      end
      @(posedge clk); #1;
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
      chk("out_instr", bus.out_instr, m_instr);
      chk("out_addr", bus.out_addr, m_addr);
      chk("err_flags", {29'd0, err_range, err_align, err_type}, {29'd0, m_er, m_ea, m_et});
      chk("word_count", 32'(word_count), 32'(m_wc));
      chk("err_count", 32'(err_count), 32'(m_ec));
   endtask

   typedef struct {
      logic [2:0]  t;
      logic [31:0] imm;
      logic [31:0] base;
      logic        legal;
      logic [31:0] instr;
   } vec_t;

   vec_t vecs[9];
   logic [31:0] bnd[8];
   logic [31:0] a0, rimm;
   logic [2:0]  rt;

   initial begin
      vecs[0] = '{3'd0, 32'hFFFF_F800, 32'h0000_0013, 1'b1, 32'h8000_0013};
      vecs[1] = '{3'd2, 32'h0000_0FFE, 32'h0000_0063, 1'b1, 32'h7E00_0FE3};
      vecs[2] = '{3'd2, 32'h0000_1000, 32'h0000_0063, 1'b0, 32'h0};
      vecs[3] = '{3'd4, 32'h0000_0003, 32'h0000_006F, 1'b0, 32'h0};
      vecs[4] = '{3'd3, 32'h1234_5000, 32'h0000_00B7, 1'b1, 32'h1234_50B7};
      vecs[5] = '{3'd3, 32'h1234_5001, 32'h0000_00B7, 1'b0, 32'h0};
      vecs[6] = '{3'd7, 32'h0000_0000, 32'h0000_0013, 1'b0, 32'h0};
      vecs[7] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0023, 1'b1, 32'hFE00_0FA3};
      vecs[8] = '{3'd4, 32'h000F_FFFE, 32'h0000_006F, 1'b1, 32'h7FFF_F06F};
      bnd = '{32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F7FF, 32'hFFFF_F000,
              32'h0000_0FFE, 32'hFFFF_EFFE, 32'h0010_0000, 32'hFFF0_0000};

      bus.in_valid = 0; bus.in_immtype = '0; bus.in_imm = '0; bus.in_base = '0;
      bus.out_ready = 1;
      model_reset();
      #12;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_addr", bus.out_addr, BASE);
      chk("rst_out_instr", bus.out_instr, 32'd0);
      chk("rst_counts", {word_count, err_count}, 32'd0);
      rst = 0;
      @(posedge clk); #1;

      // Directed table: each word offered for one cycle, then an idle cycle.
      for (int i = 0; i < 9; i++) begin
         a0 = m_next;
         cycle(1, vecs[i].t, vecs[i].imm, vecs[i].base, 1, 0, 0);
         chk("tbl_valid", {31'd0, bus.out_valid}, {31'd0, vecs[i].legal});
         if (vecs[i].legal) begin
            chk("tbl_instr", bus.out_instr, vecs[i].instr);
            chk("tbl_addr", bus.out_addr, a0);
         end
         cycle(0, 0, 0, 0, 1, 0, 0);
      end
      chk("tbl_wc", 32'(word_count), 32'd5);
      chk("tbl_ec", 32'(err_count), 32'd4);

      // Backpressure: word 1 held for 3 cycles while word 2 waits.
      a0 = m_next;
      cycle(1, 3'd0, 32'd1, 32'h0000_0013, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 3'd0, 32'd2, 32'h0000_0093, 0, 0, 0);
         chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         chk("bp_instr_hold", bus.out_instr, 32'h0010_0013);
      end
      cycle(1, 3'd0, 32'd2, 32'h0000_0093, 1, 0, 0);
      chk("bp_w2_addr", bus.out_addr, a0 + 32'd4);
      chk("bp_w2_instr", bus.out_instr, 32'h0020_0093);
      cycle(1, 3'd3, 32'h0000_3000, 32'h0000_0037, 1, 1, 32'h0000_0103);
      chk("load_addr", bus.out_addr, 32'h0000_0100);
      cycle(1, 3'd0, 32'd5, 32'h0000_0013, 1, 0, 0);
      chk("load_next", bus.out_addr, 32'h0000_0104);

      // Asynchronous reset while a word is held.
      cycle(1, 3'd0, 32'd7, 32'h0000_0013, 0, 0, 0);
      bus.in_valid = 0;
      #2 rst = 1;
      #1;
      chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("arst_addr", bus.out_addr, BASE);
      chk("arst_flags", {29'd0, err_range, err_align, err_type}, 32'd0);
      chk("arst_counts", {word_count, err_count}, 32'd0);
      model_reset();
      #2 rst = 0;
      @(posedge clk); #1;
      cycle(1, 3'd0, 32'd9, 32'h0000_0013, 1, 0, 0);
      chk("post_rst_addr", bus.out_addr, BASE);

      // Random stimulus against the model.
      for (int i = 0; i < 400; i++) begin
         rt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         case ($urandom_range(0, 3))
            0: rimm = 32'($urandom_range(0, 10000)) - 32'd5000;
            1: rimm = $urandom & 32'hFFFF_F000;
            2: rimm = $urandom;
            default: rimm = bnd[$urandom_range(0, 7)] + 32'($urandom_range(0, 2)) - 32'd1;
         endcase
         cycle($urandom_range(0, 3) != 0, rt, rimm, $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imm_pack_encoder_rv32i.md
Name: imm_pack_encoder_rv32i

Overview:
Inverse of the core's immediate extraction: packs a 32-bit signed immediate and immediate type into the immediate bit positions of an RV32I instruction word. Accepts a valid/ready stream of (base instruction, immediate, type) and range/alignment-checks each immediate. It emits legal words on a registered valid/ready stream with an auto-incrementing IMEM write address. Used by the test-program loader to build instruction memory images in hardware.

Parameters:
BASE_ADDR, 32'h0000_0000, address of first emitted word after reset
CNT_W, 16, width of word and error counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input word offered
in_ready  output  1  input word accepted when in_valid && in_ready
in_immtype  input  3  000=I, 001=S, 010=B, 011=U, 100=J
in_imm  input  32  immediate value (two's complement byte offset/value)
in_base  input  32  instruction with opcode/rd/rs1/rs2/funct fields; immediate bit positions ignored
addr_load  input  1  load address counter from addr_value
addr_value  input  32  new address, low 2 bits forced to 0
out_valid  output  1  packed word available
out_ready  input  1  consumer accepts when out_valid && out_ready
out_instr  output  32  packed instruction
out_addr  output  32  IMEM byte address of out_instr
err_range  output  1  sticky: immediate out of range seen
err_align  output  1  sticky: misaligned B/J, or U with nonzero low 12 bits
err_type  output  1  sticky: in_immtype 101..111 seen
word_count  output  CNT_W  words emitted (handshaken on output)
err_count  output  CNT_W  inputs dropped due to any error

Behaviour:
- Reset (async, immediate): out_valid=0, out_instr=0, out_addr=BASE_ADDR, all err_* =0, both counters 0. Next address register = BASE_ADDR.
- in_ready = !out_valid || out_ready (combinational). Single output register stage; latency 1 cycle from accept to out_valid.
- out_instr/out_addr held stable while out_valid && !out_ready.
- Legality checks on the accepted word:
  - I/S: in_imm[31:11] all equal.
  - B: in_imm[31:12] all equal and in_imm[0]=0.
  - J: in_imm[31:20] all equal and in_imm[0]=0.
  - U: in_imm[11:0]=0.
  - A sign failure sets err_range; an alignment failure sets err_align; both may set together.
  - Illegal type sets err_type only.
- Illegal word: dropped (out_valid not set by it; a held word may still drain), err_count += 1 (saturating), next address unchanged.
- Packing; all bits not listed are copied from in_base:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Address: a legal accepted word takes out_addr = next address, then next address += 4 (wraps at 2^32).
- word_count increments on the output handshake, saturating at all-ones.
- addr_load: loads next address in the same cycle. If a legal word is accepted in that cycle, it gets addr_value and next becomes addr_value+4 (load wins, then increment). A word already in the output register keeps its address.
- Simultaneous output drain and input accept: new word replaces old in the same edge, no bubble.
- Sticky errors clear only on rst.

Decomposition:
- Shared package: immediate-type codes (IMM_I..IMM_J), per-type sign-check MSB indices, opcode constants for benches.
- One natural sub-module: imm_pack_comb_rv32i (combinational pack + legality flags). The top holds handshake, address, counters and sticky flags.

Test Plan:
- I-type in_imm=32'hFFFF_F800, in_base=32'h0000_0013 → one cycle later out_instr=32'h8000_0013, out_addr=BASE_ADDR, word_count=1 after handshake.
- B-type in_imm=32'h0000_0FFE, in_base=32'h0000_0063 → out_instr=32'h7E00_0FE3. Then in_imm=32'h0000_1000 → dropped, err_range=1, err_count=1.
- J-type in_imm=3 → dropped, err_align=1, out_valid stays 0, next legal word still gets the old next address.
- U-type in_imm=32'h1234_5000, in_base=32'h0000_00B7 → out_instr=32'h1234_50B7. in_imm=32'h1234_5001 → err_align. in_immtype=3'b111 → err_type.
- Backpressure: out_ready=0 for 3 cycles with 2 legal words offered → in_ready=0 and out_instr stable. Release → words emerge in order at addresses A, A+4. addr_load of 32'h100 in the accept cycle of word 3 → word 3 at 32'h100.
- Reset asserted mid-cycle with out_valid=1 → out_valid, counters and flags drop to 0 before the next clk edge. First post-reset word is at BASE_ADDR.
